// File: rtl/ysyx_24110006_clint.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_clint
//
// Read-only CLINT slave with an AXI4-Lite-style read channel. It holds a
// free-running 64-bit mtime counter and a 64-bit snapshot. The snapshot lets
// software read the low word and then the high word and get one consistent
// 64-bit value, even if mtime carries into the high word between the reads.
// This slave has no write channel.
//
// Parameters
//   BASE_ADDR  address of mtime[31:0]; BASE_ADDR+4 returns the snapshot high
//   TICK_DIV   clock cycles per mtime increment (>= 1)
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   i_axi_araddr   read address
//   i_axi_arvalid  read address valid
//   o_axi_arready  read address ready (registered)
//   o_axi_rdata    read data (registered)
//   o_axi_rvalid   read data valid (registered)
//   o_axi_rresp    2'b00 OKAY, 2'b10 SLVERR (registered)
//   i_axi_rready   read data ready
// ---------------------------------------------------------------------------
module ysyx_24110006_clint #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  output logic [1:0]  o_axi_rresp,
  input  logic        i_axi_rready
);

  // The prescaler is kept at least one bit wide so that TICK_DIV=1 still has
  // a legal vector. In that case the prescaler stays at 0, and every edge is
  // a tick.
  localparam int unsigned PRESCALE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TICK_DIV - 1);
  localparam logic [31:0] HIGH_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } readState_e;

  readState_e             r_state;
  readState_e             w_nextState;
  logic [63:0]            r_mtime;
  logic [63:0]            r_snapshot;
  logic [63:0]            w_nextSnapshot;
  logic [PRESCALE_W-1:0]  r_prescaler;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic [1:0]             r_rresp;
  logic                   w_nextArready;
  logic                   w_nextRvalid;
  logic [31:0]            w_nextRdata;
  logic [1:0]             w_nextRresp;
  logic                   w_tick;
  logic                   w_arHandshake;
  logic                   w_rHandshake;

  assign w_tick        = (r_prescaler == PRESCALE_MAX);
  assign w_arHandshake = i_axi_arvalid && r_arready;
  assign w_rHandshake  = r_rvalid && i_axi_rready;

  // The timer runs independently of the bus. It never stalls, and mtime wraps
  // silently from all-ones to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescaler <= '0;
      r_mtime     <= 64'd0;
    end else begin
      r_prescaler <= w_tick ? '0 : r_prescaler + 1'b1;
      if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  // Next-state and next-output logic for the read channel.
  // A low-word read samples r_mtime as it is before this edge's increment.
  // The same value goes to both the snapshot and rdata, so a later high-word
  // read matches the low word that was returned.
  always_comb begin
    w_nextState    = r_state;
    w_nextArready  = r_arready;
    w_nextRvalid   = r_rvalid;
    w_nextRdata    = r_rdata;
    w_nextRresp    = r_rresp;
    w_nextSnapshot = r_snapshot;
    unique case (r_state)
      IDLE: begin
        w_nextArready = 1'b1;
        w_nextRvalid  = 1'b0;
        if (w_arHandshake) begin
          w_nextState   = RESP;
          w_nextArready = 1'b0;
          w_nextRvalid  = 1'b1;
          if (i_axi_araddr == BASE_ADDR) begin
            w_nextSnapshot = r_mtime;
            w_nextRdata    = r_mtime[31:0];
            w_nextRresp    = RESP_OKAY;
          end else if (i_axi_araddr == HIGH_ADDR) begin
            w_nextRdata = r_snapshot[63:32];
            w_nextRresp = RESP_OKAY;
          end else begin
            w_nextRdata = 32'd0;
            w_nextRresp = RESP_SLVERR;
          end
        end
      end
      RESP: begin
        // Ignore arvalid here. Only one read can be in flight.
        w_nextArready = 1'b0;
        w_nextRvalid  = 1'b1;
        if (w_rHandshake) begin
          w_nextState   = IDLE;
          w_nextRvalid  = 1'b0;
          w_nextArready = 1'b1;
        end
      end
      default: begin
        w_nextState   = IDLE;
        w_nextArready = 1'b0;
        w_nextRvalid  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  // Reset leaves arready low, so the slave accepts reads only from the first
  // edge after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'd0;
      r_rresp    <= RESP_OKAY;
      r_snapshot <= 64'd0;
    end else begin
      r_state    <= w_nextState;
      r_arready  <= w_nextArready;
      r_rvalid   <= w_nextRvalid;
      r_rdata    <= w_nextRdata;
      r_rresp    <= w_nextRresp;
      r_snapshot <= w_nextSnapshot;
    end
  end

  assign o_axi_arready = r_arready;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_ysyx_24110006_clint.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_clint
//
// Self-checking bench for the CLINT read slave. The bench holds a scoreboard
// queue: each read address it issues pushes the expected data and response,
// and each response from the DUT pops and compares one entry.
// A second instance with TICK_DIV=4 exercises the prescaler and the wrap of
// mtime.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] HIGH = 32'h0200_0004;
  localparam logic [31:0] BAD  = 32'h0200_0008;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } ReadExp;

  logic        clock;
  logic        reset;
  logic [31:0] axiAraddr;
  logic        axiArvalid;
  logic        axiArready;
  logic [31:0] axiRdata;
  logic        axiRvalid;
  logic [1:0]  axiRresp;
  logic        axiRready;

  logic [31:0] idleAraddr;
  logic        idleArvalid;
  logic        idleRready;
  logic        div4Arready;
  logic [31:0] div4Rdata;
  logic        div4Rvalid;
  logic [1:0]  div4Rresp;

  int          checkCount;
  int          failCount;
  logic [63:0] cycleCount;
  logic [63:0] tbDelta;
  logic [63:0] tbSnapshot;
  ReadExp      expQ[$];

  ysyx_24110006_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .i_axi_araddr (axiAraddr),
    .i_axi_arvalid(axiArvalid),
    .o_axi_arready(axiArready),
    .o_axi_rdata  (axiRdata),
    .o_axi_rvalid (axiRvalid),
    .o_axi_rresp  (axiRresp),
    .i_axi_rready (axiRready)
  );

  ysyx_24110006_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
    .clock        (clock),
    .reset        (reset),
    .i_axi_araddr (idleAraddr),
    .i_axi_arvalid(idleArvalid),
    .o_axi_arready(div4Arready),
    .o_axi_rdata  (div4Rdata),
    .o_axi_rvalid (div4Rvalid),
    .o_axi_rresp  (div4Rresp),
    .i_axi_rready (idleRready)
  );

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count the edges since reset. The expected mtime of the TICK_DIV=1 DUT is
  // this count plus any offset from a preload.
  always @(posedge clock or posedge reset) begin
    if (reset) cycleCount <= 64'd0;
    else       cycleCount <= cycleCount + 64'd1;
  end

  function automatic logic [63:0] modelMtime();
    return cycleCount + tbDelta;
  endfunction

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic printSummary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
  endtask

  // Call at a negedge. This presents the address, waits for arready within a
  // bounded time, and pushes the expectation for the handshake edge that
  // follows. It returns at the negedge after that handshake edge.
  task automatic applyStimulus(input logic [31:0] addr);
    int     waited;
    ReadExp exp;
    waited     = 0;
    axiAraddr  = addr;
    axiArvalid = 1'b1;
    while (!axiArready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!axiArready) begin
      checkOutput("arreadyTimeout", 64'(axiArready), 64'd1);
      axiArvalid = 1'b0;
      return;
    end
    if (addr == BASE) begin
      tbSnapshot = modelMtime();
      exp.data   = tbSnapshot[31:0];
      exp.resp   = 2'b00;
    end else if (addr == HIGH) begin
      exp.data = tbSnapshot[63:32];
      exp.resp = 2'b00;
    end else begin
      exp.data = 32'd0;
      exp.resp = 2'b10;
    end
    expQ.push_back(exp);
    @(posedge clock);
    @(negedge clock);
    axiArvalid = 1'b0;
  endtask

  // Call at the negedge after the handshake edge. This checks the response
  // against the scoreboard. It holds rready low for holdCycles, and drives a
  // stray address during that hold, which the DUT must ignore. It then
  // completes the R handshake.
  task automatic collectResponse(input int holdCycles, input logic [31:0] strayAddr);
    ReadExp      exp;
    logic [31:0] heldData;
    checkOutput("rvalidLatency", 64'(axiRvalid), 64'd1);
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 64'd1, 64'd0);
      exp = '0;
    end else begin
      exp = expQ.pop_front();
    end
    checkOutput("rdata", 64'(axiRdata), 64'(exp.data));
    checkOutput("rresp", 64'(axiRresp), 64'(exp.resp));
    heldData = exp.data;
    for (int i = 0; i < holdCycles; i++) begin
      if (i == 1) begin
        axiAraddr  = strayAddr;
        axiArvalid = 1'b1;
      end
      @(negedge clock);
      checkOutput("holdRvalid", 64'(axiRvalid), 64'd1);
      checkOutput("holdRdata", 64'(axiRdata), 64'(heldData));
      checkOutput("holdArready", 64'(axiArready), 64'd0);
    end
    axiArvalid = 1'b0;
    axiRready  = 1'b1;
    @(negedge clock);
    axiRready = 1'b0;
    checkOutput("postRvalid", 64'(axiRvalid), 64'd0);
    checkOutput("postArready", 64'(axiArready), 64'd1);
  endtask

  task automatic doRead(input logic [31:0] addr, input int holdCycles);
    applyStimulus(addr);
    collectResponse(holdCycles, HIGH);
  endtask

  // Watchdog in case a wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failCount++;
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount  = 0;
    failCount   = 0;
    tbDelta     = 64'd0;
    tbSnapshot  = 64'd0;
    reset       = 1'b1;
    axiAraddr   = 32'd0;
    axiArvalid  = 1'b0;
    axiRready   = 1'b0;
    idleAraddr  = 32'd0;
    idleArvalid = 1'b0;
    idleRready  = 1'b0;

    // Reset state, then 10 idle cycles
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("resetArready", 64'(axiArready), 64'd0);
    checkOutput("resetRvalid", 64'(axiRvalid), 64'd0);
    checkOutput("resetRdata", 64'(axiRdata), 64'd0);
    checkOutput("resetRresp", 64'(axiRresp), 64'd0);
    checkOutput("resetMtime", dut.r_mtime, 64'd0);
    @(negedge clock);
    checkOutput("arreadyCycle1", 64'(axiArready), 64'd1);
    repeat (9) @(negedge clock);
    checkOutput("mtimeAfter10", dut.r_mtime, 64'd10);

    // Prescaler of 4: 16 cycles give mtime=4. Preload all-ones, and one tick
    // later mtime wraps to 0.
    repeat (6) @(negedge clock);
    checkOutput("div4After16", dut4.r_mtime, 64'd4);
    checkOutput("div1After16", dut.r_mtime, modelMtime());
    dut4.r_mtime = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(negedge clock);
    checkOutput("div4BeforeWrap", dut4.r_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    checkOutput("div4Wrapped", dut4.r_mtime, 64'd0);

    // A high-word read before any low-word read returns 0
    doRead(HIGH, 0);

    // Low-word read on a carry edge, then a high-word read from the snapshot
    dut.r_mtime = 64'h0000_0001_FFFF_FFFF;
    tbDelta     = 64'h0000_0001_FFFF_FFFF - cycleCount;
    doRead(BASE, 0);
    checkOutput("mtimeCrossed", dut.r_mtime, modelMtime());
    doRead(HIGH, 0);

    // Back-pressure on R with a stray arvalid that must be ignored
    doRead(BASE, 5);
    doRead(HIGH, 0);

    // An unmapped address gives SLVERR and leaves the snapshot unchanged
    doRead(BAD, 0);
    doRead(HIGH, 0);

    // Reset while a response is pending
    applyStimulus(BASE);
    checkOutput("preResetRvalid", 64'(axiRvalid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRvalid", 64'(axiRvalid), 64'd0);
    checkOutput("asyncArready", 64'(axiArready), 64'd0);
    checkOutput("asyncMtime", dut.r_mtime, 64'd0);
    expQ.delete();
    tbDelta    = 64'd0;
    tbSnapshot = 64'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    doRead(BASE, 0);
    doRead(HIGH, 0);

    checkOutput("scoreboardDrained", 64'(expQ.size()), 64'd0);
    printSummary();
    $finish;
  end

endmodule
